// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a parallel word as start, LSB-first data,
// optional parity and stop bit, and gates the external parity calculator.
module uart_tx_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             par_bit,
  output logic             par_calc_en,
  output logic             TX_OUT,
  output logic             BUSY
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] data_q, data_n;
  logic             par_en_q, par_en_n;
  logic             tx_n, busy_n;
  logic             ready;
  logic             accept;

  // A new word may only be taken (and its parity latched) in IDLE or STOP
  assign ready       = (state == IDLE) || (state == STOP);
  assign accept      = ready && DATA_VALID;
  assign par_calc_en = ready;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      TX_OUT   <= 1'b1;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      data_q   <= data_n;
      par_en_q <= par_en_n;
      TX_OUT   <= tx_n;
      BUSY     <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    data_n   = data_q;
    par_en_n = par_en_q;
    tx_n     = 1'b1;
    busy_n   = 1'b1;

    case (state)
      IDLE, STOP: begin
        if (accept) begin
          state_n  = START;
          data_n   = P_DATA;
          par_en_n = PAR_EN;
          cnt_n    = '0;
        end else begin
          state_n  = IDLE;
        end
      end
      START:  state_n = DATA;
      DATA: begin
        if (cnt == LAST) begin
          state_n = par_en_q ? PARITY : STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PARITY: state_n = STOP;
      default: state_n = IDLE;
    endcase

    // Line level and busy follow the state being entered at this edge
    case (state_n)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
      end
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_q[cnt_n];
      PARITY:  tx_n = par_bit;
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural parity calculator;
// checks line level, busy and calculator enable cycle by cycle.
module tb_uart_tx_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             CLK;
  logic             RST;
  logic [WIDTH-1:0] P_DATA;
  logic             DATA_VALID;
  logic             PAR_EN;
  logic             par_typ;
  logic             par_bit;
  logic             par_calc_en;
  logic             TX_OUT;
  logic             BUSY;

  int errors = 0;
  int checks = 0;

  uart_tx_ctrl #(.WIDTH(WIDTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .par_calc_en(par_calc_en),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Parity calculator: even (typ 0) or odd (typ 1), latched on enable+valid
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) par_bit <= 1'b0;
    else if (par_calc_en && DATA_VALID) par_bit <= par_typ ? ~(^P_DATA) : (^P_DATA);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; par_typ = 1'b0;
    #13;
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || par_calc_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: tx=%b busy=%b pce=%b want 1 0 1", TX_OUT, BUSY, par_calc_en);
    end
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || par_calc_en !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle[%0d]: tx=%b busy=%b pce=%b want 1 0 1", i, TX_OUT, BUSY, par_calc_en);
      end
    end
  endtask

  task automatic test_no_parity();
    logic [9:0] exp_tx;
    exp_tx = 10'b0101001011;
    P_DATA = 8'hA5; PAR_EN = 1'b0; DATA_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      DATA_VALID = 1'b0;
      checks++;
      if (TX_OUT !== exp_tx[9-i] || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL nopar_bit[%0d]: tx=%b busy=%b want %b 1", i, TX_OUT, BUSY, exp_tx[9-i]);
      end
    end
    tick();
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || par_calc_en !== 1'b1) begin
      errors++;
      $display("FAIL nopar_idle: tx=%b busy=%b pce=%b want 1 0 1", TX_OUT, BUSY, par_calc_en);
    end
  endtask

  task automatic test_parity(input logic typ, input logic [10:0] exp_tx);
    par_typ = typ;
    P_DATA = 8'h07; PAR_EN = 1'b1; DATA_VALID = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      DATA_VALID = 1'b0;
      checks++;
      if (TX_OUT !== exp_tx[10-i] || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL par%0d_bit[%0d]: tx=%b busy=%b want %b 1", typ, i, TX_OUT, BUSY, exp_tx[10-i]);
      end
    end
    tick();
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL par%0d_idle: tx=%b busy=%b want 1 0", typ, TX_OUT, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp_tx;
    exp_tx = {11'b00011110001, 11'b01100001101};
    par_typ = 1'b0;
    P_DATA = 8'h3C; PAR_EN = 1'b1; DATA_VALID = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      checks++;
      if (TX_OUT !== exp_tx[21-i] || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL b2b_bit[%0d]: tx=%b busy=%b want %b 1", i, TX_OUT, BUSY, exp_tx[21-i]);
      end
      if (i == 10) begin
        DATA_VALID = 1'b1; P_DATA = 8'hC3;
      end else begin
        DATA_VALID = 1'b0;
      end
    end
    tick();
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: tx=%b busy=%b want 1 0", TX_OUT, BUSY);
    end
  endtask

  task automatic test_ignore_inputs();
    logic [10:0] exp_tx;
    exp_tx = 11'b01111111101;
    par_typ = 1'b0;
    P_DATA = 8'hFF; PAR_EN = 1'b1; DATA_VALID = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (TX_OUT !== exp_tx[10-i] || BUSY !== 1'b1 || par_calc_en !== (i == 10)) begin
        errors++;
        $display("FAIL ignore_bit[%0d]: tx=%b busy=%b pce=%b want %b 1 %b",
                 i, TX_OUT, BUSY, par_calc_en, exp_tx[10-i], (i == 10));
      end
      if (i < 9) begin
        P_DATA = 8'h00; PAR_EN = ~PAR_EN; DATA_VALID = ~DATA_VALID;
      end else begin
        DATA_VALID = 1'b0;
      end
    end
    tick();
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: tx=%b busy=%b want 1 0", TX_OUT, BUSY);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp_tx;
    P_DATA = 8'h00; PAR_EN = 1'b0; DATA_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      DATA_VALID = 1'b0;
    end
    checks++;
    if (TX_OUT !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: tx=%b busy=%b want 0 1", TX_OUT, BUSY);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0 || par_calc_en !== 1'b1) begin
      errors++;
      $display("FAIL rst_abort: tx=%b busy=%b pce=%b want 1 0 1", TX_OUT, BUSY, par_calc_en);
    end
    #1 RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL rst_idle[%0d]: tx=%b busy=%b want 1 0", i, TX_OUT, BUSY);
      end
    end
    exp_tx = 10'b0101010101;
    P_DATA = 8'h55; PAR_EN = 1'b0; DATA_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      DATA_VALID = 1'b0;
      checks++;
      if (TX_OUT !== exp_tx[9-i] || BUSY !== 1'b1) begin
        errors++;
        $display("FAIL rst_after_bit[%0d]: tx=%b busy=%b want %b 1", i, TX_OUT, BUSY, exp_tx[9-i]);
      end
    end
    tick();
    checks++;
    if (TX_OUT !== 1'b1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_idle: tx=%b busy=%b want 1 0", TX_OUT, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity(1'b0, 11'b01110000011);
    test_parity(1'b1, 11'b01110000001);
    test_back_to_back();
    test_ignore_inputs();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
